// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Fixed latency DATA_WIDTH+1 cycles from start to the one-cycle done strobe; busy stalls the issuer.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op1,
  input  logic [DATA_WIDTH-1:0]    op2,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out,
  output logic                     we
);
  localparam int W = DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]               cnt;
  logic [2:0]               fn_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [W-1:0]             op1_q, b_q;
  logic [2*W-1:0]           acc;
  logic                     neg_q, rem_neg_q, div0_q, ovf_q;

  logic         is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [W-1:0] mag_a, mag_b;
  logic [W:0]   sum, rem_sh, diff;
  logic [2*W-1:0] mul_nxt, div_nxt, prod;
  logic [W-1:0] q, r, fin;

  // Operand decode at issue: signedness, magnitudes and the two divide special cases
  always_comb begin
    is_div = funct3[2];
    a_sgn  = is_div ? ~funct3[0] : (funct3 != 3'b011);
    b_sgn  = is_div ? ~funct3[0] : ~funct3[1];
    a_neg  = a_sgn & op1[W-1];
    b_neg  = b_sgn & op2[W-1];
    mag_a  = a_neg ? -op1 : op1;
    mag_b  = b_neg ? -op2 : op2;
    div0   = (op2 == '0);
    ovf    = is_div & ~funct3[0] & (op1 == {1'b1, {(W-1){1'b0}}}) & (op2 == '1);
  end

  // Multiply: acc = {partial, multiplier} shifted right; divide: acc = {remainder, quotient} shifted left
  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_nxt = {sum, acc[W-1:1]};
    rem_sh  = acc[2*W-1:W-1];
    diff    = rem_sh - {1'b0, b_q};
    div_nxt = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                      : {diff[W-1:0],   acc[W-2:0], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    q    = acc[W-1:0];
    r    = acc[2*W-1:W];
    fin  = '0;
    if (fn_q[2]) begin
      if (div0_q)     fin = fn_q[1] ? op1_q : '1;
      else if (ovf_q) fin = fn_q[1] ? '0 : op1_q;
      else            fin = fn_q[1] ? (rem_neg_q ? -r : r) : (neg_q ? -q : q);
    end else begin
      fin = (fn_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !flush;
  assign we   = done && (rd_out != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fn_q      <= '0;
      rd_q      <= '0;
      op1_q     <= '0;
      b_q       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && !flush) begin
        cnt       <= '0;
        fn_q      <= funct3;
        rd_q      <= rd_in;
        op1_q     <= op1;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= div0;
        ovf_q     <= ovf;
        b_q       <= is_div ? mag_b : mag_a;
        acc       <= is_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
      end else if (state == BUSY && !flush) begin
        // The extra cycle after the last iteration applies sign fix-up and special cases
        if (cnt != LAST) begin
          acc <= fn_q[2] ? div_nxt : mul_nxt;
          cnt <= cnt + 6'd1;
        end else begin
          result <= fin;
          rd_out <= rd_q;
        end
      end
    end
  end
endmodule
